// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles big-endian words from a byte
// stream, writes them to consecutive word addresses and verifies a trailing checksum.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-2:0] load_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int CNT_W = ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] next_word_count;
    logic [CNT_W-1:0] next_words_loaded;
    logic [1:0]       byte_idx;
    logic [1:0]       next_byte_idx;
    logic [31:0]      word_buf;
    logic [31:0]      next_word_buf;
    logic [7:0]       sum;
    logic [7:0]       next_sum;
    logic [7:0]       check_total;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        next_word_count   = word_count;
        next_words_loaded = words_loaded;
        next_byte_idx     = byte_idx;
        next_word_buf     = word_buf;
        next_sum          = sum;
        accept            = in_valid && in_ready;
        check_total       = sum + in_data;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_words_loaded = '0;
                    next_byte_idx     = '0;
                    next_sum          = '0;
                    next_word_buf     = '0;
                    next_word_count   = load_words;
                    if (int'(load_words) > MAX_WORDS) begin
                        next_state = ERR;
                    end else if (load_words == '0) begin
                        next_state = CHECK;
                    end else begin
                        next_state = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    // Shifting in from the bottom leaves the first byte in [31:24] after four transfers.
                    next_word_buf = {word_buf[23:0], in_data};
                    next_sum      = sum + in_data;
                    next_byte_idx = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                next_words_loaded = words_loaded + CNT_W'(1);
                next_state        = (next_words_loaded == word_count) ? CHECK : RECV;
            end
            CHECK: begin
                if (accept) begin
                    next_state = (check_total == 8'd0) ? DONE : ERR;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count   <= '0;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            sum          <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            word_count   <= next_word_count;
            words_loaded <= next_words_loaded;
            byte_idx     <= next_byte_idx;
            word_buf     <= next_word_buf;
            sum          <= next_sum;
            in_ready     <= (next_state == RECV) || (next_state == CHECK);
            mem_we       <= (next_state == WRITE);
            if (next_state == WRITE) begin
                mem_addr  <= {words_loaded[ADDR_W-3:0], 2'b00};
                mem_wdata <= next_word_buf;
            end
            cpu_hold <= (next_state != DONE);
            busy     <= (next_state == RECV) || (next_state == WRITE) || (next_state == CHECK);
            done     <= (next_state == DONE);
            error    <= (next_state == ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven single-word loads plus
// hand-written multi-word, gap, empty, oversize, mid-load reset and full-memory sequences.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  load_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] src[64];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  cks;
        logic        ok;
    } vec_t;

    vec_t vecs[7];

    imem_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_words   (load_words),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Record every write strobe; the loader must never offer in_ready while writing.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            checkOutput("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    function automatic logic [7:0] word_sum(input logic [31:0] w);
        logic [7:0] s;
        s = w[31:24];
        s = s + w[23:16];
        s = s + w[15:8];
        s = s + w[7:0];
        return s;
    endfunction

    task automatic applyStimulus(input int n);
        start      = 1'b1;
        load_words = 7'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("byte_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic check_single(input string tag, input logic [31:0] w, input logic ok);
        checkOutput({tag, "_nwrites"}, q_addr.size(), 1);
        if (q_addr.size() > 0) begin
            checkOutput({tag, "_addr"}, {24'd0, q_addr[0]}, 32'h0);
            checkOutput({tag, "_data"}, q_data[0], w);
        end
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, ok});
        checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
        checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !ok});
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_wl"}, {25'd0, words_loaded}, 32'd1);
    endtask

    initial begin
        logic [7:0] s;
        logic       seen;

        vecs[0] = '{32'hE3A01005, 8'h68, 1'b1};
        vecs[1] = '{32'hE3A01005, 8'h69, 1'b0};
        vecs[2] = '{32'h00000000, 8'h00, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 8'h04, 1'b1};
        vecs[4] = '{32'h12345678, 8'hEC, 1'b1};
        vecs[5] = '{32'h12345678, 8'h14, 1'b0};
        vecs[6] = '{32'hDEADBEEF, 8'hC8, 1'b1};

        reset = 1'b1; start = 1'b0; load_words = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_addr", {24'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("rst_flags", {29'd0, busy, done, error}, 32'd0);
        checkOutput("rst_wl", {25'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] table-driven single-word loads");
        for (int i = 0; i < 7; i++) begin
            clear_log();
            applyStimulus(1);
            checkOutput("start_busy", {31'd0, busy}, 32'd1);
            checkOutput("start_hold", {31'd0, cpu_hold}, 32'd1);
            checkOutput("start_ready", {31'd0, in_ready}, 32'd1);
            checkOutput("start_clr", {30'd0, done, error}, 32'd0);
            send_word(vecs[i].word, 0);
            send_byte(vecs[i].cks, 0);
            check_single($sformatf("vec%0d", i), vecs[i].word, vecs[i].ok);
        end

        $display("[TB] retry after error with start and in_valid together");
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'hE3;
        applyStimulus(1);
        send_byte(8'hE3, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h10, 0);
        send_byte(8'h05, 0);
        send_byte(8'h68, 0);
        check_single("retry", 32'hE3A01005, 1'b1);

        $display("[TB] three words with gaps, start while busy");
        clear_log();
        src[0] = 32'h01020304; src[1] = 32'h0A0B0C0D; src[2] = 32'h10203040;
        s = 8'd0;
        applyStimulus(3);
        for (int i = 0; i < 3; i++) begin
            send_word(src[i], 3);
            s = s + word_sum(src[i]);
            if (i == 0) applyStimulus(1);
        end
        send_byte(8'd0 - s, 2);
        checkOutput("w3_nwrites", q_addr.size(), 3);
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checkOutput($sformatf("w3_addr%0d", i), {24'd0, q_addr[i]}, 32'(4 * i));
            checkOutput($sformatf("w3_data%0d", i), q_data[i], src[i]);
        end
        checkOutput("w3_done", {31'd0, done}, 32'd1);
        checkOutput("w3_wl", {25'd0, words_loaded}, 32'd3);

        $display("[TB] empty load and oversize load");
        clear_log();
        applyStimulus(0);
        checkOutput("zero_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h00, 0);
        checkOutput("zero_nwrites", q_addr.size(), 0);
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        checkOutput("zero_hold", {31'd0, cpu_hold}, 32'd0);
        applyStimulus(65);
        checkOutput("over_error", {31'd0, error}, 32'd1);
        checkOutput("over_done", {31'd0, done}, 32'd0);
        checkOutput("over_hold", {31'd0, cpu_hold}, 32'd1);
        seen = in_ready;
        repeat (5) begin
            @(negedge clk);
            seen = seen | in_ready;
        end
        checkOutput("over_ready_never", {31'd0, seen}, 32'd0);
        checkOutput("over_nwrites", q_addr.size(), 0);

        $display("[TB] reset in the middle of word 1");
        clear_log();
        applyStimulus(2);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mid_rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("mid_rst_addr", {24'd0, mem_addr}, 32'd0);
        checkOutput("mid_rst_wdata", mem_wdata, 32'd0);
        checkOutput("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("mid_rst_flags", {29'd0, busy, done, error}, 32'd0);
        checkOutput("mid_rst_wl", {25'd0, words_loaded}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_rst_nwrites", q_addr.size(), 1);
        clear_log();
        applyStimulus(1);
        send_word(32'hE3A01005, 0);
        send_byte(8'h68, 0);
        check_single("after_rst", 32'hE3A01005, 1'b1);

        $display("[TB] full 64-word load");
        clear_log();
        s = 8'd0;
        for (int i = 0; i < 64; i++) begin
            src[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            s = s + word_sum(src[i]);
        end
        applyStimulus(64);
        for (int i = 0; i < 64; i++) send_word(src[i], 0);
        send_byte(8'd0 - s, 0);
        checkOutput("full_nwrites", q_addr.size(), 64);
        for (int i = 0; i < 64 && i < q_addr.size(); i++) begin
            checkOutput($sformatf("full_addr%0d", i), {24'd0, q_addr[i]}, 32'(4 * i));
            checkOutput($sformatf("full_data%0d", i), q_data[i], src[i]);
        end
        checkOutput("full_wl", {25'd0, words_loaded}, 32'd64);
        checkOutput("full_done", {31'd0, done}, 32'd1);
        checkOutput("full_hold", {31'd0, cpu_hold}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory ROM that the pipeline's PC reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word at consecutive word-aligned byte addresses and verifies a trailing 8-bit checksum.
- Holds the CPU (PC / IF-ID enables) stalled until a load completes cleanly; replaces simulation-only file preloading with a synthesizable load path.

Parameters:
ADDR_W, 8, instruction memory byte-address width (matches the 8-bit PC).
MAX_WORDS, 64, capacity in words; must equal 2**ADDR_W / 4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR).
load_words  input  ADDR_W-1  number of words to load, sampled on start; legal 0..MAX_WORDS.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader can accept a byte this cycle.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  byte address of the word being written (multiple of 4).
mem_wdata  output  32  instruction word being written.
cpu_hold  output  1  1 = PC and IF/ID must not advance.
busy  output  1  load in progress (RECV, WRITE, CHECK).
done  output  1  last load succeeded; held until the next start.
error  output  1  last load failed; held until the next start.
words_loaded  output  ADDR_W-1  count of words written in the current or last load.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Byte counter and checksum accumulator are cleared.
  - Memory contents already written are not touched.
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR. All outputs are registered.
- IDLE / DONE / ERR, on start:
  - Clears done, error, words_loaded, byte index and checksum sum.
  - Latches load_words. If load_words > MAX_WORDS, go to ERR (error=1). If load_words = 0, go to CHECK. Otherwise go to RECV.
  - cpu_hold becomes 1 on the cycle after start in every case.
- start is ignored while busy.
- RECV:
  - in_ready=1. A byte transfers when in_valid & in_ready.
  - Byte k (k=0..3) of the word goes to bits [31-8k -: 8], big-endian: first byte is [31:24].
  - Each accepted byte is added into an 8-bit sum (mod 256).
  - in_valid gaps are allowed; no timeout.
  - The transfer of the 4th byte moves the state to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=4*words_loaded, mem_wdata=assembled word, in_ready=0.
  - Next cycle: words_loaded increments and mem_we returns to 0.
  - Next state is CHECK if words_loaded+1 = latched count, else RECV.
  - Write cadence: at most one word per 5 cycles.
- CHECK:
  - in_ready=1; accepts exactly one checksum byte.
  - If (sum + byte) mod 256 = 0, go to DONE; else go to ERR.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR: error=1, cpu_hold=1, in_ready=0.
- mem_addr wraps naturally. With load_words = MAX_WORDS the final address is 4*(MAX_WORDS-1) (0xFC at defaults); it never overflows.
- Reset mid-load (any state): immediate return to IDLE with the reset values above. A partially assembled word is discarded and no mem_we is issued.
- in_valid while in_ready=0: byte not consumed; the upstream holds it.
- start and in_valid in the same cycle in IDLE: only start acts; in_ready is 0 that cycle, so the byte is not taken.

Test Plan:
1. reset; start, load_words=1; bytes E3,A0,10,05, checksum 68 -> one mem_we with mem_addr=0x00, mem_wdata=32'hE3A01005; then done=1, cpu_hold=0, words_loaded=1.
2. load_words=3 with random in_valid gaps (12 data bytes + correct checksum) -> mem_we at addresses 0x00, 0x04, 0x08 in order with the correct words; in_ready=0 in each WRITE cycle; done=1.
3. Same as scenario 1 but checksum byte 69 -> word still written at 0x00; error=1, done=0, cpu_hold=1; a subsequent start with the correct stream gives done=1.
4. load_words=0, then checksum byte 00 -> no mem_we; done=1. load_words=65 -> error=1 the cycle after start; in_ready never asserted.
5. reset pulsed after 2 bytes of word 1 (word 0 already written) -> all outputs return to reset values immediately; no further mem_we; a fresh 1-word load writes 0x00.
6. load_words=64 with incrementing-pattern words -> 64 writes, last at mem_addr=0xFC; words_loaded=64; done=1.
